sar_ctrl: RTL and testbench

SAR_CTRL -- requirements
Module: sar_ctrl

---
 rtl/sar_pkg.sv | 14 +
 rtl/cmp_sync.sv | 24 ++
 rtl/sar_ctrl.sv | 136 +++++++++++++
 tb/tb_sar_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared types and defaults for the successive-approximation ADC controller.
package sar_pkg;

    localparam int SAR_SIZE_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        SETTLE,
        DECIDE,
        DONE
    } sar_state_t;

endpackage

// File: rtl/cmp_sync.sv
// Two-flop synchronizer bringing the asynchronous comparator output into clk.
module cmp_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/sar_ctrl.sv
// SAR conversion sequencer: sample, then per bit (MSB first) settle the DAC
// trial code and decide the bit from the synchronized comparator.
module sar_ctrl
    import sar_pkg::*;
#(
    parameter int SIZE = SAR_SIZE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            cmp,
    input  logic [3:0]      sample_cyc,
    input  logic [3:0]      settle_cyc,
    output logic            sample,
    output logic [SIZE-1:0] dac_code,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] data,
    output logic            overrun
);

    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    sar_state_t       state_reg, state_next;
    logic             start_q_reg;
    logic             rst_q_reg;
    logic [4:0]       cnt_reg, cnt_next;
    logic [IDX_W-1:0] bit_reg, bit_next;
    logic [SIZE-1:0]  code_reg, code_next;
    logic [SIZE-1:0]  data_reg, data_next;
    logic [3:0]       settle_len_reg, settle_len_next;
    logic             overrun_reg, overrun_next;
    logic             cmp_s;
    logic             start_edge;

    cmp_sync u_cmp_sync (
        .clk (clk),
        .rst (rst),
        .d   (cmp),
        .q   (cmp_s)
    );

    // The cycle right after reset is blanked so a start level held through
    // reset release is not mistaken for a fresh edge.
    assign start_edge = start & ~start_q_reg & ~rst_q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            start_q_reg    <= 1'b0;
            rst_q_reg      <= 1'b1;
            cnt_reg        <= '0;
            bit_reg        <= '0;
            code_reg       <= '0;
            data_reg       <= '0;
            settle_len_reg <= '0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            start_q_reg    <= start;
            rst_q_reg      <= 1'b0;
            cnt_reg        <= cnt_next;
            bit_reg        <= bit_next;
            code_reg       <= code_next;
            data_reg       <= data_next;
            settle_len_reg <= settle_len_next;
            overrun_reg    <= overrun_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        bit_next        = bit_reg;
        code_next       = code_reg;
        data_next       = data_reg;
        settle_len_next = settle_len_reg;
        overrun_next    = start_edge && (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                if (start_edge) begin
                    state_next      = SAMPLE;
                    cnt_next        = {1'b0, sample_cyc};
                    settle_len_next = settle_cyc;
                    code_next       = '0;
                end
            end
            SAMPLE: begin
                if (cnt_reg == 5'd0) begin
                    state_next            = SETTLE;
                    bit_next              = IDX_W'(SIZE - 1);
                    code_next             = '0;
                    code_next[SIZE-1]     = 1'b1;
                    cnt_next              = {1'b0, settle_len_reg} + 5'd1;
                end else begin
                    cnt_next = cnt_reg - 5'd1;
                end
            end
            SETTLE: begin
                // Loaded with settle+1 so the synchronizer sees two stable edges.
                if (cnt_reg == 5'd0) begin
                    state_next = DECIDE;
                end else begin
                    cnt_next = cnt_reg - 5'd1;
                end
            end
            DECIDE: begin
                code_next[bit_reg] = cmp_s;
                if (bit_reg == '0) begin
                    state_next = DONE;
                    data_next  = code_next;
                end else begin
                    state_next                      = SETTLE;
                    bit_next                        = bit_reg - IDX_W'(1);
                    code_next[bit_reg - IDX_W'(1)]  = 1'b1;
                    cnt_next                        = {1'b0, settle_len_reg} + 5'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign sample   = (state_reg == SAMPLE);
    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);
    assign dac_code = code_reg;
    assign data     = data_reg;
    assign overrun  = overrun_reg;

endmodule

// File: tb/tb_sar_ctrl.sv
// Self-checking bench for sar_ctrl: table of conversions plus directed
// overrun, mid-conversion reset and held-start sequences.
module tb_sar_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       cmp;
    logic [3:0] sample_cyc;
    logic [3:0] settle_cyc;
    logic       sample;
    logic [7:0] dac_code;
    logic       busy;
    logic       done;
    logic [7:0] data;
    logic       overrun;
    logic [7:0] vin;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [7:0] vin;
        logic [3:0] sc;
        logic [3:0] st;
        logic [7:0] exp_data;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ideal comparator: Ain at or above the DAC trial level reads as 1.
    assign cmp = (vin >= dac_code);

    sar_ctrl #(.SIZE(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cmp        (cmp),
        .sample_cyc (sample_cyc),
        .settle_cyc (settle_cyc),
        .sample     (sample),
        .dac_code   (dac_code),
        .busy       (busy),
        .done       (done),
        .data       (data),
        .overrun    (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_expired(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("done_data", data, mon_e.data);
                check("done_cycle", cyc, mon_e.cyc);
                $display("conversion done: cycle %0d data %02h (expected %02h at cycle %0d)",
                         cyc, data, mon_e.data, mon_e.cyc);
            end
        end
    end

    task automatic run_conv(input logic [7:0] v, input logic [3:0] sc, input logic [3:0] st,
                            input logic [7:0] exp_data);
        int t0;
        int lat;
        int nb;
        int ns;
        bit fin;
        vin        = v;
        sample_cyc = sc;
        settle_cyc = st;
        start      = 1'b1;
        t0         = cyc;
        lat        = 1 + (int'(sc) + 1) + 8 * (int'(st) + 3);
        sb.push_back('{exp_data, t0 + lat});
        nb  = 0;
        ns  = 0;
        fin = 1'b0;
        for (int c = 0; c < 300 && !fin; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy)   nb++;
            if (sample) ns++;
            if (cyc == t0 + int'(sc) + 2) check("first_settle_code", dac_code, 8'h80);
            if (done)   fin = 1'b1;
        end
        if (!fin) bound_expired("conv_done_wait");
        check("busy_cycles", nb, lat);
        check("sample_cycles", ns, int'(sc) + 1);
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        check("busy_after_done", busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int nb;
        int nd;
        int no;

        vecs[0] = '{8'hA5, 4'd0,  4'd0,  8'hA5};
        vecs[1] = '{8'h00, 4'd0,  4'd0,  8'h00};
        vecs[2] = '{8'hFF, 4'd0,  4'd0,  8'hFF};
        vecs[3] = '{8'h3C, 4'd3,  4'd2,  8'h3C};
        vecs[4] = '{8'h5A, 4'd1,  4'd1,  8'h5A};
        vecs[5] = '{8'h01, 4'd0,  4'd15, 8'h01};
        vecs[6] = '{8'h80, 4'd15, 4'd0,  8'h80};
        vecs[7] = '{8'h7F, 4'd2,  4'd3,  8'h7F};

        // Reset with start already high; release must not start a conversion.
        rst        = 1'b1;
        start      = 1'b1;
        vin        = 8'h00;
        sample_cyc = 4'd0;
        settle_cyc = 4'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_sample", sample, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        check("reset_dac_code", dac_code, 8'h00);
        check("reset_data", data, 8'h00);
        rst = 1'b0;
        nb  = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy) nb++;
        end
        check("held_start_through_reset", nb, 0);
        start = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            $display("vector %0d: vin %02h sample_cyc %0d settle_cyc %0d",
                     i, vecs[i].vin, vecs[i].sc, vecs[i].st);
            run_conv(vecs[i].vin, vecs[i].sc, vecs[i].st, vecs[i].exp_data);
        end

        // Overrun, with timing inputs changed mid-conversion.
        vin        = 8'h77;
        sample_cyc = 4'd1;
        settle_cyc = 4'd1;
        start      = 1'b1;
        t0         = cyc;
        sb.push_back('{8'h77, t0 + 1 + 2 + 8 * 4});
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start      = 1'b1;
        sample_cyc = 4'd7;
        settle_cyc = 4'd9;
        @(negedge clk);
        check("overrun_pulse", overrun, 1'b1);
        start = 1'b0;
        @(negedge clk);
        check("overrun_one_cycle", overrun, 1'b0);
        nd = 0;
        no = 0;
        repeat (60) begin
            @(negedge clk);
            if (done)    nd++;
            if (overrun) no++;
        end
        check("overrun_single_done", nd, 1);
        check("overrun_no_more_pulses", no, 0);
        check("overrun_data", data, 8'h77);
        check("overrun_sb_drained", sb.size(), 0);

        // Reset during bit 4 of a conversion of 0x5A.
        vin        = 8'h5A;
        sample_cyc = 4'd0;
        settle_cyc = 4'd0;
        start      = 1'b1;
        t0         = cyc;
        for (int c = 0; c < 40 && cyc != t0 + 12; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("bit4_trial_code", dac_code, 8'h50);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs", {sample, busy, done, overrun, dac_code, data}, 20'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_idle", busy, 1'b0);
        run_conv(8'h5A, 4'd0, 4'd0, 8'h5A);

        // Start held high for 100 cycles: exactly one conversion.
        vin   = 8'hC3;
        start = 1'b1;
        t0    = cyc;
        sb.push_back('{8'hC3, t0 + 26});
        nd = 0;
        repeat (100) begin
            @(negedge clk);
            if (done) nd++;
        end
        start = 1'b0;
        check("held_start_single_done", nd, 1);
        @(negedge clk);
        check("held_sb_drained", sb.size(), 0);
        check("held_data", data, 8'hC3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
